// File: rtl/rom_arbiter_pkg.sv
// Shared types for rom_arbiter: boot FSM states, requester IDs and the
// word-alignment helper used on every granted address.
package rom_arbiter_pkg;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef enum logic {
        REQ_IF  = 1'b0,
        REQ_LSU = 1'b1
    } req_id_e;

    localparam int GNT_IF  = 0;
    localparam int GNT_LSU = 1;

    function automatic logic is_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/rom_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: under contention the requester that did not
// win last time is granted; the pointer only moves when something is granted.
module rr_arb2
    import rom_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    req_id_e last_q;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last_q == REQ_LSU) ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= REQ_LSU;
        end else if (gnt[GNT_IF]) begin
            last_q <= REQ_IF;
        end else if (gnt[GNT_LSU]) begin
            last_q <= REQ_LSU;
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Owns both rom ports: the loader writes during BOOT, then IF and LSU share
// the read port round-robin in RUN while all ROM writes are refused.
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter bit BOOT_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    output logic          if_err,
    input  logic          lsu_req,
    input  logic          lsu_we,
    input  logic [AW-1:0] lsu_addr,
    input  logic [DW-1:0] lsu_wdata,
    output logic          lsu_gnt,
    output logic          lsu_rvalid,
    output logic [DW-1:0] lsu_rdata,
    output logic          lsu_err,
    input  logic          ld_req,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_gnt,
    input  logic          ld_done,
    output logic          boot,
    output logic          rom_wen,
    output logic [AW-1:0] rom_w_addr,
    output logic [DW-1:0] rom_w_data,
    output logic          rom_ren,
    output logic [AW-1:0] rom_r_addr,
    input  logic [DW-1:0] rom_r_data
);

    state_e        state;
    logic          in_boot;
    logic          in_run;
    logic [1:0]    rd_req;
    logic [1:0]    rd_gnt;
    logic          lsu_wr_gnt;
    logic [AW-1:0] rd_addr;
    logic          rd_ok;
    logic          if_rvalid_q, if_err_q;
    logic          lsu_rvalid_q, lsu_err_q;
    logic          unused_lsu_wdata;

    // Writes are always refused once running, so the LSU write data has no sink.
    assign unused_lsu_wdata = ^lsu_wdata;

    // Everything is held off during the reset cycle itself.
    assign in_boot = (state == ST_BOOT) && !rst;
    assign in_run  = (state == ST_RUN) && !rst;

    assign rd_req = in_run ? {lsu_req && !lsu_we, if_req} : 2'b00;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (rd_req),
        .gnt (rd_gnt)
    );

    assign lsu_wr_gnt = in_run && lsu_req && lsu_we;

    assign if_gnt  = rd_gnt[GNT_IF];
    assign lsu_gnt = rd_gnt[GNT_LSU] || lsu_wr_gnt;
    assign ld_gnt  = in_boot && ld_req;

    assign rom_wen    = ld_gnt && is_aligned(ld_addr[1:0]);
    assign rom_w_addr = ld_addr;
    assign rom_w_data = ld_wdata;

    assign rd_addr    = rd_gnt[GNT_LSU] ? lsu_addr : if_addr;
    assign rd_ok      = is_aligned(rd_addr[1:0]);
    assign rom_ren    = (|rd_gnt) && rd_ok;
    assign rom_r_addr = rd_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            if (BOOT_EN) begin
                state <= ST_BOOT;
            end else begin
                state <= ST_RUN;
            end
            if_rvalid_q  <= 1'b0;
            if_err_q     <= 1'b0;
            lsu_rvalid_q <= 1'b0;
            lsu_err_q    <= 1'b0;
        end else begin
            if (state == ST_BOOT && ld_done) begin
                state <= ST_RUN;
            end
            if_rvalid_q  <= rd_gnt[GNT_IF];
            if_err_q     <= rd_gnt[GNT_IF] && !rd_ok;
            lsu_rvalid_q <= lsu_gnt;
            lsu_err_q    <= lsu_wr_gnt || (rd_gnt[GNT_LSU] && !rd_ok);
        end
    end

    // A response registered before a reset must not escape during it.
    assign if_rvalid  = if_rvalid_q && !rst;
    assign if_err     = if_err_q && !rst;
    assign if_rdata   = (if_rvalid && !if_err_q) ? rom_r_data : '0;
    assign lsu_rvalid = lsu_rvalid_q && !rst;
    assign lsu_err    = lsu_err_q && !rst;
    assign lsu_rdata  = (lsu_rvalid && !lsu_err_q) ? rom_r_data : '0;

    assign boot = rst ? BOOT_EN : (state == ST_BOOT);

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: one instance booting through the loader, one with
// BOOT_EN=0, each backed by a small one-cycle-latency ROM model.
module tb_rom_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk, rst, preload;
    logic          if_req, if_gnt, if_rvalid, if_err;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          lsu_req, lsu_we, lsu_gnt, lsu_rvalid, lsu_err;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_wdata, lsu_rdata;
    logic          ld_req, ld_gnt, ld_done, boot;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          rom_wen, rom_ren;
    logic [AW-1:0] rom_w_addr, rom_r_addr;
    logic [DW-1:0] rom_w_data, rom_r_data;

    logic          n_if_req, n_if_gnt, n_if_rvalid, n_if_err;
    logic [AW-1:0] n_if_addr;
    logic [DW-1:0] n_if_rdata;
    logic          n_lsu_req, n_lsu_we, n_lsu_gnt, n_lsu_rvalid, n_lsu_err;
    logic [AW-1:0] n_lsu_addr;
    logic [DW-1:0] n_lsu_wdata, n_lsu_rdata;
    logic          n_ld_req, n_ld_gnt, n_ld_done, n_boot;
    logic [AW-1:0] n_ld_addr;
    logic [DW-1:0] n_ld_wdata;
    logic          n_rom_wen, n_rom_ren;
    logic [AW-1:0] n_rom_w_addr, n_rom_r_addr;
    logic [DW-1:0] n_rom_w_data, n_rom_r_data;

    logic [DW-1:0] mem_a [0:63];
    logic [DW-1:0] mem_b [0:63];

    // {owner (1=LSU), err, rdata}
    logic [DW+1:0] exp_q[$];
    int n_total = 0;
    int n_pass  = 0;

    rom_arbiter #(.DW(DW), .AW(AW), .BOOT_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
        .ld_done(ld_done), .boot(boot),
        .rom_wen(rom_wen), .rom_w_addr(rom_w_addr), .rom_w_data(rom_w_data),
        .rom_ren(rom_ren), .rom_r_addr(rom_r_addr), .rom_r_data(rom_r_data)
    );

    rom_arbiter #(.DW(DW), .AW(AW), .BOOT_EN(1'b0)) dut_nb (
        .clk(clk), .rst(rst),
        .if_req(n_if_req), .if_addr(n_if_addr), .if_gnt(n_if_gnt),
        .if_rvalid(n_if_rvalid), .if_rdata(n_if_rdata), .if_err(n_if_err),
        .lsu_req(n_lsu_req), .lsu_we(n_lsu_we), .lsu_addr(n_lsu_addr), .lsu_wdata(n_lsu_wdata),
        .lsu_gnt(n_lsu_gnt), .lsu_rvalid(n_lsu_rvalid), .lsu_rdata(n_lsu_rdata), .lsu_err(n_lsu_err),
        .ld_req(n_ld_req), .ld_addr(n_ld_addr), .ld_wdata(n_ld_wdata), .ld_gnt(n_ld_gnt),
        .ld_done(n_ld_done), .boot(n_boot),
        .rom_wen(n_rom_wen), .rom_w_addr(n_rom_w_addr), .rom_w_data(n_rom_w_data),
        .rom_ren(n_rom_ren), .rom_r_addr(n_rom_r_addr), .rom_r_data(n_rom_r_data)
    );

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM models: write port immediate, read data registered one cycle
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) begin
                mem_a[i] <= pat(32'(i) << 2);
                mem_b[i] <= pat(32'(i) << 2);
            end
        end else begin
            if (rom_wen) mem_a[rom_w_addr[7:2]] <= rom_w_data;
            if (n_rom_wen) mem_b[n_rom_w_addr[7:2]] <= n_rom_w_data;
        end
        if (rom_ren) rom_r_data <= mem_a[rom_r_addr[7:2]];
        if (n_rom_ren) n_rom_r_data <= mem_b[n_rom_r_addr[7:2]];
    end

    // scoreboard: pops every response expected from the previous cycle
    task automatic sb_check(input string tag);
        logic [DW+1:0] e;
        logic exp_if_v, exp_lsu_v;
        exp_if_v = 1'b0;
        exp_lsu_v = 1'b0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (e[DW+1]) begin
                exp_lsu_v = 1'b1;
                n_total++; if (lsu_err !== e[DW]) $display("FAIL %s lsu_err got=%0b exp=%0b", tag, lsu_err, e[DW]); else n_pass++;
                n_total++; if (lsu_rdata !== e[DW-1:0]) $display("FAIL %s lsu_rdata got=%h exp=%h", tag, lsu_rdata, e[DW-1:0]); else n_pass++;
            end else begin
                exp_if_v = 1'b1;
                n_total++; if (if_err !== e[DW]) $display("FAIL %s if_err got=%0b exp=%0b", tag, if_err, e[DW]); else n_pass++;
                n_total++; if (if_rdata !== e[DW-1:0]) $display("FAIL %s if_rdata got=%h exp=%h", tag, if_rdata, e[DW-1:0]); else n_pass++;
            end
        end
        n_total++; if (if_rvalid !== exp_if_v) $display("FAIL %s if_rvalid got=%0b exp=%0b", tag, if_rvalid, exp_if_v); else n_pass++;
        n_total++; if (lsu_rvalid !== exp_lsu_v) $display("FAIL %s lsu_rvalid got=%0b exp=%0b", tag, lsu_rvalid, exp_lsu_v); else n_pass++;
        if (!exp_if_v) begin
            n_total++; if ({if_err, if_rdata} !== '0) $display("FAIL %s if_idle got=%0b/%h exp=0/0", tag, if_err, if_rdata); else n_pass++;
        end
        if (!exp_lsu_v) begin
            n_total++; if ({lsu_err, lsu_rdata} !== '0) $display("FAIL %s lsu_idle got=%0b/%h exp=0/0", tag, lsu_err, lsu_rdata); else n_pass++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; if_req = 1'b1; lsu_req = 1'b1; ld_req = 1'b1; n_if_req = 1'b1; n_ld_req = 1'b1;
        #1;
        n_total++; if (boot !== 1'b1) $display("FAIL reset_boot got=%0b exp=1", boot); else n_pass++;
        n_total++; if (n_boot !== 1'b0) $display("FAIL reset_nb_boot got=%0b exp=0", n_boot); else n_pass++;
        n_total++; if ({if_gnt, lsu_gnt, ld_gnt} !== 3'b000) $display("FAIL reset_gnt got=%b exp=000", {if_gnt, lsu_gnt, ld_gnt}); else n_pass++;
        n_total++; if ({n_if_gnt, n_ld_gnt} !== 2'b00) $display("FAIL reset_nb_gnt got=%b exp=00", {n_if_gnt, n_ld_gnt}); else n_pass++;
        n_total++; if ({rom_wen, rom_ren} !== 2'b00) $display("FAIL reset_rom_en got=%b exp=00", {rom_wen, rom_ren}); else n_pass++;
        sb_check("reset_resp");
        @(negedge clk);
        rst = 1'b0; if_req = 1'b0; lsu_req = 1'b0; ld_req = 1'b0; n_if_req = 1'b0; n_ld_req = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_boot_load();
        @(negedge clk);
        rst = 1'b0;
        ld_req = 1'b1; ld_addr = 32'h10; ld_wdata = 32'hDEADBEEF; if_req = 1'b1; if_addr = 32'h10;
        #1;
        sb_check("boot_c0");
        n_total++; if (ld_gnt !== 1'b1) $display("FAIL boot_ld_gnt got=%0b exp=1", ld_gnt); else n_pass++;
        n_total++; if (rom_wen !== 1'b1) $display("FAIL boot_wen got=%0b exp=1", rom_wen); else n_pass++;
        n_total++; if ({rom_w_addr, rom_w_data} !== {32'h10, 32'hDEADBEEF}) $display("FAIL boot_wport got=%h/%h exp=10/deadbeef", rom_w_addr, rom_w_data); else n_pass++;
        n_total++; if (if_gnt !== 1'b0) $display("FAIL boot_if_stall got=%0b exp=0", if_gnt); else n_pass++;
        n_total++; if (rom_ren !== 1'b0) $display("FAIL boot_ren got=%0b exp=0", rom_ren); else n_pass++;
        @(negedge clk);
        ld_addr = 32'h13; ld_wdata = 32'h55555555;
        #1;
        sb_check("boot_c1");
        n_total++; if ({ld_gnt, rom_wen} !== 2'b10) $display("FAIL boot_misaligned got=%b exp=10", {ld_gnt, rom_wen}); else n_pass++;
        @(negedge clk);
        ld_addr = 32'h14; ld_wdata = 32'h12345678; ld_done = 1'b1;
        #1;
        n_total++; if ({boot, rom_wen} !== 2'b11) $display("FAIL boot_done_write got=%b exp=11", {boot, rom_wen}); else n_pass++;
        @(negedge clk);
        ld_done = 1'b0; ld_addr = 32'h18;
        #1;
        sb_check("boot_c3");
        n_total++; if ({boot, ld_gnt, rom_wen} !== 3'b000) $display("FAIL run_entry got=%b exp=000", {boot, ld_gnt, rom_wen}); else n_pass++;
        n_total++; if ({if_gnt, rom_ren} !== 2'b11) $display("FAIL run_if_gnt got=%b exp=11", {if_gnt, rom_ren}); else n_pass++;
        n_total++; if (rom_r_addr !== 32'h10) $display("FAIL run_raddr got=%h exp=10", rom_r_addr); else n_pass++;
        exp_q.push_back({1'b0, 1'b0, 32'hDEADBEEF});
        @(negedge clk);
        ld_req = 1'b0; if_addr = 32'h14;
        #1;
        sb_check("boot_rd10");
        exp_q.push_back({1'b0, 1'b0, 32'h12345678});
        @(negedge clk);
        if_req = 1'b0;
        #1;
        sb_check("boot_rd14");
    endtask

    task automatic test_back_to_back();
        logic [3:0] seq;
        seq = 4'b0101; // bit i = 1: IF expected to win cycle i
        @(negedge clk);
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h10;
        #1;
        n_total++; if ({if_gnt, lsu_gnt} !== 2'b01) $display("FAIL b2b_sole_lsu got=%b exp=01", {if_gnt, lsu_gnt}); else n_pass++;
        exp_q.push_back({1'b1, 1'b0, 32'hDEADBEEF});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if_req = 1'b1; if_addr = 32'h0; lsu_addr = 32'h4;
            #1;
            sb_check($sformatf("b2b_%0d", i));
            n_total++; if ({if_gnt, lsu_gnt} !== {seq[i], !seq[i]}) $display("FAIL b2b_gnt_%0d got=%b exp=%b", i, {if_gnt, lsu_gnt}, {seq[i], !seq[i]}); else n_pass++;
            if (seq[i]) exp_q.push_back({1'b0, 1'b0, pat(32'h0)});
            else exp_q.push_back({1'b1, 1'b0, pat(32'h4)});
        end
        @(negedge clk);
        if_req = 1'b0; lsu_req = 1'b0;
        #1;
        sb_check("b2b_tail");
    endtask

    task automatic test_lsu_write();
        @(negedge clk);
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 32'h8; lsu_wdata = 32'hBAD0BAD0;
        if_req = 1'b1; if_addr = 32'hC;
        #1;
        n_total++; if ({lsu_gnt, if_gnt, rom_wen, rom_ren} !== 4'b1101) $display("FAIL wr_gnt got=%b exp=1101", {lsu_gnt, if_gnt, rom_wen, rom_ren}); else n_pass++;
        exp_q.push_back({1'b0, 1'b0, pat(32'hC)});
        exp_q.push_back({1'b1, 1'b1, 32'h0});
        @(negedge clk);
        if_req = 1'b0;
        #1;
        sb_check("wr_a");
        n_total++; if ({lsu_gnt, rom_wen, rom_ren} !== 3'b100) $display("FAIL wr_alone got=%b exp=100", {lsu_gnt, rom_wen, rom_ren}); else n_pass++;
        exp_q.push_back({1'b1, 1'b1, 32'h0});
        @(negedge clk);
        lsu_we = 1'b0; if_req = 1'b1; if_addr = 32'h0;
        #1;
        sb_check("wr_b");
        n_total++; if ({if_gnt, lsu_gnt} !== 2'b01) $display("FAIL wr_ptr_kept got=%b exp=01", {if_gnt, lsu_gnt}); else n_pass++;
        exp_q.push_back({1'b1, 1'b0, pat(32'h8)});
        @(negedge clk);
        lsu_req = 1'b0;
        #1;
        sb_check("wr_rd8");
        exp_q.push_back({1'b0, 1'b0, pat(32'h0)});
        @(negedge clk);
        if_req = 1'b0;
        #1;
        sb_check("wr_tail");
    endtask

    task automatic test_misaligned();
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h6;
        #1;
        n_total++; if ({if_gnt, rom_ren} !== 2'b10) $display("FAIL mis_if got=%b exp=10", {if_gnt, rom_ren}); else n_pass++;
        exp_q.push_back({1'b0, 1'b1, 32'h0});
        @(negedge clk);
        if_req = 1'b0; lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h2;
        #1;
        sb_check("mis_if_resp");
        n_total++; if ({lsu_gnt, rom_ren} !== 2'b10) $display("FAIL mis_lsu got=%b exp=10", {lsu_gnt, rom_ren}); else n_pass++;
        exp_q.push_back({1'b1, 1'b1, 32'h0});
        @(negedge clk);
        lsu_req = 1'b0;
        #1;
        sb_check("mis_lsu_resp");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h0;
        #1;
        n_total++; if (if_gnt !== 1'b1) $display("FAIL rmid_gnt got=%0b exp=1", if_gnt); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        sb_check("rmid_rst_cycle");
        n_total++; if ({boot, if_gnt} !== 2'b10) $display("FAIL rmid_rst got=%b exp=10", {boot, if_gnt}); else n_pass++;
        @(negedge clk);
        rst = 1'b0; lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h4;
        #1;
        sb_check("rmid_after");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            n_total++; if ({boot, if_gnt, lsu_gnt} !== 3'b100) $display("FAIL rmid_stall_%0d got=%b exp=100", i, {boot, if_gnt, lsu_gnt}); else n_pass++;
        end
        @(negedge clk);
        ld_done = 1'b1;
        #1;
        n_total++; if ({if_gnt, lsu_gnt} !== 2'b00) $display("FAIL rmid_done_cycle got=%b exp=00", {if_gnt, lsu_gnt}); else n_pass++;
        @(negedge clk);
        ld_done = 1'b0;
        #1;
        sb_check("rmid_idle");
        n_total++; if ({if_gnt, lsu_gnt} !== 2'b10) $display("FAIL rmid_first_win got=%b exp=10", {if_gnt, lsu_gnt}); else n_pass++;
        exp_q.push_back({1'b0, 1'b0, pat(32'h0)});
        @(negedge clk);
        if_req = 1'b0;
        #1;
        sb_check("rmid_if_resp");
        n_total++; if (lsu_gnt !== 1'b1) $display("FAIL rmid_lsu_gnt got=%0b exp=1", lsu_gnt); else n_pass++;
        exp_q.push_back({1'b1, 1'b0, pat(32'h4)});
        @(negedge clk);
        lsu_req = 1'b0;
        #1;
        sb_check("rmid_lsu_resp");
    endtask

    task automatic test_no_boot();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_if_req = 1'b1; n_if_addr = 32'h20;
        n_ld_req = 1'b1; n_ld_addr = 32'h20; n_ld_wdata = 32'hFFFF0000;
        #1;
        n_total++; if ({n_boot, n_if_gnt, n_rom_ren} !== 3'b011) $display("FAIL nb_first got=%b exp=011", {n_boot, n_if_gnt, n_rom_ren}); else n_pass++;
        n_total++; if ({n_ld_gnt, n_rom_wen} !== 2'b00) $display("FAIL nb_ld got=%b exp=00", {n_ld_gnt, n_rom_wen}); else n_pass++;
        @(negedge clk);
        n_if_req = 1'b0;
        #1;
        n_total++; if ({n_if_rvalid, n_if_err} !== 2'b10) $display("FAIL nb_resp got=%b exp=10", {n_if_rvalid, n_if_err}); else n_pass++;
        n_total++; if (n_if_rdata !== pat(32'h20)) $display("FAIL nb_rdata got=%h exp=%h", n_if_rdata, pat(32'h20)); else n_pass++;
        n_total++; if ({n_ld_gnt, n_rom_wen} !== 2'b00) $display("FAIL nb_ld2 got=%b exp=00", {n_ld_gnt, n_rom_wen}); else n_pass++;
        @(negedge clk);
        n_ld_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; preload = 1'b1;
        if_req = 1'b0; if_addr = '0;
        lsu_req = 1'b0; lsu_we = 1'b0; lsu_addr = '0; lsu_wdata = '0;
        ld_req = 1'b0; ld_addr = '0; ld_wdata = '0; ld_done = 1'b0;
        n_if_req = 1'b0; n_if_addr = '0;
        n_lsu_req = 1'b0; n_lsu_we = 1'b0; n_lsu_addr = '0; n_lsu_wdata = '0;
        n_ld_req = 1'b0; n_ld_addr = '0; n_ld_wdata = '0; n_ld_done = 1'b0;
        repeat (2) @(negedge clk);
        preload = 1'b0;

        test_reset();
        test_boot_load();
        test_back_to_back();
        test_lsu_write();
        test_misaligned();
        test_reset_mid();
        test_no_boot();

        n_total++; if (exp_q.size() != 0) $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
